// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT input loader: sample type, loader FSM
// state encoding and a width-parameterised bit-reverse.
package fft_pkg;

    localparam int SAMPLE_W = 32;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Reverse the low 'width' bits of value; bits above 'width' come back zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < width) begin
                r[b] = value[width-1-b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_input_loader_fifo.sv
// loader_fifo: synchronous FIFO with a registered head entry and an occupancy
// count. A push and a pop in the same cycle are both honoured when the FIFO is
// full; when it is empty the pop is ignored and the push lands in the head.
module loader_fifo
    import fft_pkg::*;
#(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = DEPTH[PW:0];
    localparam logic [PW:0] ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_next;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign rd_next = rd_ptr + 1'b1;
    assign valid   = (count != '0);

    // Entry storage: written at the tail, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered head: refill from the next stored entry, or straight from the
    // write port when the FIFO is (or becomes) otherwise empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
        end else if (do_pop) begin
            if (count > ONE) begin
                head <= mem[rd_next];
            end else if (do_push) begin
                head <= din;
            end
        end else if (do_push && (count == '0)) begin
            head <= din;
        end
    end

endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: reads one N-point frame from a registered sample ROM and
// streams it to the FFT core over valid/ready. Reads are only issued while
// the output FIFO has room for every read already in flight, so ROM data can
// always be captured without stalling.
// Build option: define FFT_LOADER_BITREV_EN to read the ROM in bit-reversed
// order (decimation-in-time input); otherwise samples are read in natural order.
module fft_input_loader
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LOG2_N     = 3,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_rd_en,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [LOG2_N-1:0]     out_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int N       = 1 << LOG2_N;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W   = CNT_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + LOG2_N;

    localparam logic [LOG2_N-1:0]     LAST_IDX     = LOG2_N'(N - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE         = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [SUM_W-1:0]      CREDIT_LIMIT = SUM_W'(FIFO_DEPTH);

    state_t              state;
    state_t              state_next;
    logic [LOG2_N-1:0]   issue_cnt;
    logic [LOG2_N-1:0]   issue_cnt_next;
    logic [LOG2_N-1:0]   issue_idx;
    logic [LOG2_N-1:0]   seq_idx;
    logic                issue;
    logic                done_next;

    logic [LOG2_N-1:0]   rom_tag;
    logic                cap_en;
    logic [LOG2_N-1:0]   cap_tag;

    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  fifo_head;
    logic                fifo_valid;
    logic [SUM_W-1:0]    occupancy;
    logic                credit_ok;
    logic                take;
    logic                last_take;

`ifdef FFT_LOADER_BITREV_EN
    assign seq_idx = LOG2_N'(bitrev(32'(issue_idx), LOG2_N));
`else
    assign seq_idx = issue_idx;
`endif

    // Buffered samples plus reads still travelling through the ROM pipeline.
    assign occupancy = SUM_W'(fifo_count) + SUM_W'(rom_rd_en) + SUM_W'(cap_en);
    assign credit_ok = (occupancy < CREDIT_LIMIT);

    assign take      = fifo_valid && out_ready;
    assign last_take = take && (fifo_head[ENTRY_W-1 -: LOG2_N] == LAST_IDX);

    // Next-state, read-issue and completion decisions.
    always_comb begin
        state_next     = state;
        issue          = 1'b0;
        issue_idx      = issue_cnt;
        issue_cnt_next = issue_cnt;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next     = RUN;
                    issue          = 1'b1;
                    issue_idx      = '0;
                    issue_cnt_next = LOG2_N'(1);
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue          = 1'b1;
                    issue_cnt_next = issue_cnt + 1'b1;
                    if (issue_cnt == LAST_IDX) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_take) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state and issue counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
        end else begin
            state     <= state_next;
            issue_cnt <= issue_cnt_next;
        end
    end

    // ROM request, capture strobe one cycle behind it, and the done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_rd_en <= 1'b0;
            rom_addr  <= '0;
            cap_en    <= 1'b0;
            done      <= 1'b0;
        end else begin
            rom_rd_en <= issue;
            if (issue) begin
                rom_addr <= BASE + ADDR_WIDTH'(seq_idx);
            end
            cap_en <= rom_rd_en;
            done   <= done_next;
        end
    end

    // Stream-position tag riding alongside each read through the ROM latency.
    always_ff @(posedge clk) begin
        if (issue) begin
            rom_tag <= issue_idx;
        end
        cap_tag <= rom_tag;
    end

    loader_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_en),
        .din   ({cap_tag, rom_data}),
        .pop   (take),
        .head  (fifo_head),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign out_valid = fifo_valid;
    assign out_data  = fifo_head[DATA_WIDTH-1:0];
    assign out_idx   = fifo_head[ENTRY_W-1 -: LOG2_N];
    assign out_last  = (out_idx == LAST_IDX);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader: drives frames with several out_ready patterns
// and compares against a frame model built from the ROM image and read order.
module tb_fft_input_loader;
    import fft_pkg::*;

    localparam int DW     = 32;
    localparam int AW     = 12;
    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;
    localparam int BASE   = 0;
    localparam int DEPTH  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          out_ready;
    logic [AW-1:0] rom_addr;
    logic          rom_rd_en;
    logic [DW-1:0] rom_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [LOG2_N-1:0] out_idx;
    logic          out_last;
    logic          busy;
    logic          done;

    sample_t rom_img [4096];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fft_input_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LOG2_N     (LOG2_N),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_rd_en (rom_rd_en),
        .rom_data  (rom_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    // Registered sample ROM, one-cycle read latency.
    always @(posedge clk) rom_data <= rom_img[rom_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Read order of stream position i.
    function automatic int seq_of(input int i);
`ifdef FFT_LOADER_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < LOG2_N; b++) begin
            if (((i >> b) & 1) != 0) r = r | (1 << (LOG2_N - 1 - b));
        end
        return r;
`else
        return i;
`endif
    endfunction

    function automatic int exp_addr(input int i);
        return (BASE + seq_of(i)) % 4096;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_rom_addr"},  rom_addr,  0);
        check({tag, "_rom_rd_en"}, rom_rd_en, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_idx"},   out_idx,   0);
        check({tag, "_out_last"},  out_last,  0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
    endtask

    // mode 0: ready high; 1: ready low cycles 3..12; 2: random 30% ready;
    // 3: ready high with extra start pulses in cycles 2 and 5.
    task automatic run_frame(input string name, input int mode, input int abort_c,
                             input bit skip_start, input bit chain_next);
        int iss = 0;
        int acc = 0;
        int done_cnt = 0;
        int done_c = -1;
        int last_c = -1;
        int first_v = -1;
        int c;
        bit held = 1'b0;
        bit aborted = 1'b0;
        logic [DW-1:0] h_data = '0;
        logic [LOG2_N-1:0] h_idx = '0;
        c = skip_start ? 1 : 0;
        while (1) begin
            start = (c == 0 && !skip_start) || (mode == 3 && (c == 2 || c == 5)) ||
                    (chain_next && c == N + 3);
            case (mode)
                1:       out_ready = !(c >= 3 && c <= 12);
                2:       out_ready = ($urandom_range(0, 9) < 3);
                default: out_ready = 1'b1;
            endcase
            rst_n = (c != abort_c);
            @(negedge clk);
            if (abort_c >= 0 && c == abort_c + 1) begin
                check_reset_vals({name, "_abort"});
                aborted = 1'b1;
            end else if (aborted) begin
                if (done) done_cnt++;
            end else begin
                if (c == 1) check({name, "_busy_rise"}, busy, 1);
                if (rom_rd_en) begin
                    check({name, "_rd_count"}, iss < N, 1);
                    check($sformatf("%s_addr%0d", name, iss), rom_addr, exp_addr(iss));
                    iss++;
                end
                check({name, "_credit"}, (iss - acc) <= DEPTH, 1);
                if (mode == 1 && c == 12) check({name, "_stall_fill"}, iss, DEPTH);
                if (held) begin
                    check({name, "_hold_valid"}, out_valid, 1);
                    check({name, "_hold_data"}, out_data, h_data);
                    check({name, "_hold_idx"}, out_idx, h_idx);
                end
                if (out_valid && first_v < 0) first_v = c;
                if (out_valid && out_ready) begin
                    if (acc < N) begin
                        check($sformatf("%s_data%0d", name, acc), out_data, rom_img[exp_addr(acc)]);
                        check($sformatf("%s_idx%0d", name, acc), out_idx, acc);
                        check($sformatf("%s_last%0d", name, acc), out_last, acc == N - 1);
                        if (acc == N - 1) last_c = c;
                    end else begin
                        check({name, "_extra_sample"}, 1, 0);
                    end
                    acc++;
                end
                held   = out_valid && !out_ready;
                h_data = out_data;
                h_idx  = out_idx;
                if (done) begin
                    done_cnt++;
                    done_c = c;
                    check({name, "_busy_at_done"}, busy, 0);
                end
            end
            @(posedge clk);
            #1;
            if (aborted && c >= abort_c + 4) break;
            if (chain_next && c == N + 3) break;
            if (!chain_next && done_c >= 0 && c >= done_c + 1) break;
            c++;
            if (c > 300) begin
                check({name, "_timeout"}, 0, 1);
                break;
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        if (aborted) begin
            check({name, "_abort_no_done"}, done_cnt, 0);
        end else begin
            check({name, "_accepted"}, acc, N);
            check({name, "_done_once"}, done_cnt, 1);
            check({name, "_done_after_last"}, done_c, last_c + 1);
            if (mode == 0 || mode == 3) begin
                check({name, "_first_valid"}, first_v, 3);
                check({name, "_last_cycle"}, last_c, N + 2);
                check({name, "_done_cycle"}, done_c, N + 3);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_img[i] = $urandom;
        rom_img[0] = 32'h00000000;
        rom_img[1] = 32'h00000000;
        rom_img[2] = 32'hBF3504F3;
        rom_img[3] = 32'hBF800000;
        rom_img[4] = 32'hBF3504F3;
        rom_img[5] = 32'hA50D3131;
        rom_img[6] = 32'h3F3504F3;
        rom_img[7] = 32'h3F800000;

        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("init");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_frame("nat",    0, -1, 1'b0, 1'b0);
        run_frame("stall",  1, -1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) run_frame($sformatf("rand%0d", k), 2, -1, 1'b0, 1'b0);
        run_frame("restart", 3, -1, 1'b0, 1'b1);
        run_frame("chain",   0, -1, 1'b1, 1'b0);
        run_frame("abort",   0,  6, 1'b0, 1'b0);
        run_frame("after",   0, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
